display_source_scheduler: RTL and testbench



---
 rtl/display_ctrl_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/display_source_scheduler.sv | 158 +++++++++++++++
 tb/tb_display_source_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_ctrl_pkg
//   Shared types and default constants for the seven-segment display
//   control path.
//   Contents:
//     disp_sched_state_t : scheduler FSM state encoding (also exported on the
//                          scheduler's dbg_state port)
//     DISP_NUM_SRC       : default number of display requesters
//     DISP_DWELL_CYCLES  : default dwell time per shown value (1 s at 100 MHz)
// -----------------------------------------------------------------------------
package display_ctrl_pkg;

    localparam int DISP_NUM_SRC      = 4;
    localparam int DISP_DWELL_CYCLES = 100_000_000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARB      = 3'd1,
        S_SHOW     = 3'd2,
        S_HOLD     = 3'd3,
        S_OVERRIDE = 3'd4
    } disp_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Searches the request vector upward
//   starting one past the previous winner, wrapping modulo N, and returns the
//   first requesting index. Holds no state; the caller owns last_grant.
//   Ports:
//     req        in  [N-1:0]  request vector
//     last_grant in  [IW-1:0] index granted most recently
//     grant      out [IW-1:0] winning index (0 when any_req is low)
//     any_req    out          at least one request is high
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = last_grant;
        // Walk the ring once, starting at last_grant+1; the wrap is explicit
        // so N need not be a power of two.
        for (int off = 0; off < N; off++) begin
            if (idx == IW'(N - 1)) begin
                idx = '0;
            end else begin
                idx = idx + IW'(1);
            end
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/display_source_scheduler.sv
// -----------------------------------------------------------------------------
// display_source_scheduler
//   Time-shares the 32-bit display value between NUM_SRC requesters. Grants
//   round-robin, latches the granted value and shows it for DWELL_CYCLES
//   cycles plus one arbitration cycle. A level-sensitive override preempts
//   the rotation at once and is tracked every cycle while high.
//
//   Handshake: a source raises src_req[i] with src_data[i] stable and keeps
//   both until src_ack[i] pulses high for exactly one cycle; that pulse marks
//   the cycle in which the value is already on `number`. The source may drop
//   req in its ack cycle; requests are ignored during SHOW, so it cannot be
//   granted twice.
//
//   Ports:
//     clk, reset      clock; synchronous active-high reset
//     src_req         [NUM_SRC]     per-source request
//     src_data        [NUM_SRC][32] per-source value
//     src_ack         [NUM_SRC]     registered one-cycle capture pulse
//     override_valid  level, display override_data while high
//     override_data   [32]          override value
//     number          [32]          value driven to the display
//     active_src      index of the source currently shown
//     active_valid    number holds a granted source value
//     in_override     override is being displayed
//     dbg_state       current FSM state
// -----------------------------------------------------------------------------
module display_source_scheduler
    import display_ctrl_pkg::*;
#(
    parameter int NUM_SRC      = DISP_NUM_SRC,
    parameter int DWELL_CYCLES = DISP_DWELL_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [NUM_SRC-1:0][31:0]      src_data,
    output logic [NUM_SRC-1:0]            src_ack,
    input  logic                          override_valid,
    input  logic [31:0]                   override_data,
    output logic [31:0]                   number,
    output logic [$clog2(NUM_SRC)-1:0]    active_src,
    output logic                          active_valid,
    output logic                          in_override,
    output disp_sched_state_t             dbg_state
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);

    disp_sched_state_t state_q, state_d;
    logic [31:0]       number_q, number_d;
    logic [IW-1:0]     active_src_q, active_src_d;
    logic              active_valid_q, active_valid_d;
    logic              in_override_q, in_override_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [IW-1:0]     arb_grant;
    logic              arb_any;

    rr_arbiter #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_arb (
        .req        (src_req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

    always_comb begin
        state_d        = state_q;
        number_d       = number_q;
        active_src_d   = active_src_q;
        active_valid_d = active_valid_q;
        in_override_d  = in_override_q;
        ack_d          = '0;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;

        if (override_valid) begin
            // Override beats everything, including a same-cycle grant; the
            // rotation bookkeeping is left untouched and the dwell is lost.
            state_d       = S_OVERRIDE;
            number_d      = override_data;
            in_override_d = 1'b1;
            cnt_d         = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_ARB, S_HOLD: begin
                    if (arb_any) begin
                        state_d              = S_SHOW;
                        number_d             = src_data[arb_grant];
                        active_src_d         = arb_grant;
                        active_valid_d       = 1'b1;
                        ack_d[arb_grant]     = 1'b1;
                        last_grant_d         = arb_grant;
                        cnt_d                = CNT_LOAD;
                    end else if (state_q == S_ARB) begin
                        state_d = S_HOLD;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == '0) begin
                        state_d = S_ARB;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_OVERRIDE: begin
                    // Released: re-arbitrate next cycle. With nobody waiting,
                    // the display keeps the stale override value, which is
                    // not a source value.
                    state_d       = S_ARB;
                    in_override_d = 1'b0;
                    if (!arb_any) begin
                        active_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            number_q       <= '0;
            active_src_q   <= '0;
            active_valid_q <= 1'b0;
            in_override_q  <= 1'b0;
            ack_q          <= '0;
            last_grant_q   <= IW'(NUM_SRC - 1);
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            number_q       <= number_d;
            active_src_q   <= active_src_d;
            active_valid_q <= active_valid_d;
            in_override_q  <= in_override_d;
            ack_q          <= ack_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
        end
    end

    assign number       = number_q;
    assign active_src   = active_src_q;
    assign active_valid = active_valid_q;
    assign in_override  = in_override_q;
    assign src_ack      = ack_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
module tb_display_source_scheduler;
    import display_ctrl_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int DWELL   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_SRC-1:0]       src_req = '0;
    logic [NUM_SRC-1:0][31:0] src_data = '0;
    logic [NUM_SRC-1:0]       src_ack;
    logic                     override_valid = 1'b0;
    logic [31:0]              override_data = '0;
    logic [31:0]              number;
    logic [1:0]               active_src;
    logic                     active_valid;
    logic                     in_override;
    disp_sched_state_t        dbg_state;

    display_source_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_req        (src_req),
        .src_data       (src_data),
        .src_ack        (src_ack),
        .override_valid (override_valid),
        .override_data  (override_data),
        .number         (number),
        .active_src     (active_src),
        .active_valid   (active_valid),
        .in_override    (in_override),
        .dbg_state      (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Expected outputs after each edge. busy counts edges still owed to the
    // current dwell; while busy or just released from override, no grant.
    logic [31:0]        m_number = '0;
    int                 m_src = 0;
    bit                 m_valid = 0;
    bit                 m_ovr = 0;
    logic [NUM_SRC-1:0] m_ack = '0;
    int                 m_last = NUM_SRC - 1;
    int                 m_busy = 0;

    function automatic int rr_pick(input logic [NUM_SRC-1:0] r, input int last);
        for (int off = 1; off <= NUM_SRC; off++) begin
            if (r[(last + off) % NUM_SRC]) return (last + off) % NUM_SRC;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        m_ack = '0;
        if (reset) begin
            m_number = '0; m_src = 0; m_valid = 0; m_ovr = 0;
            m_last = NUM_SRC - 1; m_busy = 0;
        end else if (override_valid) begin
            m_number = override_data;
            m_ovr = 1;
            m_busy = 0;
        end else if (m_ovr) begin
            m_ovr = 0;
            if (src_req == '0) m_valid = 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (src_req != '0) begin
            g = rr_pick(src_req, m_last);
            m_number = src_data[g];
            m_src = g;
            m_valid = 1;
            m_ack[g] = 1'b1;
            m_last = g;
            m_busy = DWELL;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("number", number, m_number);
            chk("active_src", 32'(active_src), 32'(m_src));
            chk("active_valid", 32'(active_valid), 32'(m_valid));
            chk("in_override", 32'(in_override), 32'(m_ovr));
            chk("src_ack", 32'(src_ack), 32'(m_ack));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int gap;
        logic [31:0] hold_val;

        // reset state
        reset = 1'b1;
        step();
        check_en = 1'b1;
        chk("rst_number", number, 32'h0);
        chk("rst_active_src", 32'(active_src), 32'h0);
        chk("rst_active_valid", 32'(active_valid), 32'h0);
        chk("rst_in_override", 32'(in_override), 32'h0);
        chk("rst_src_ack", 32'(src_ack), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // single request, one-cycle capture
        reset = 1'b0;
        src_req = 4'b0001;
        src_data[0] = 32'hDEAD_BEEF;
        step();
        chk("cap_number", number, 32'hDEAD_BEEF);
        chk("cap_active_src", 32'(active_src), 32'h0);
        chk("cap_ack", 32'(src_ack), 32'h1);
        chk("cap_valid", 32'(active_valid), 32'h1);
        src_req = '0;
        step();
        chk("cap_ack_drop", 32'(src_ack), 32'h0);

        // all four requesting: order 0,1,2,3,0 with DWELL+1 cycle spacing
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src_data[i] = 32'hA0A0_0000 + 32'(i);
        src_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            gap = 0;
            do begin
                step();
                gap++;
            end while (src_ack == '0 && gap < 12);
            chk("rr_ack", 32'(src_ack), 32'(1) << (k % NUM_SRC));
            chk("rr_number", number, 32'hA0A0_0000 + 32'(k % NUM_SRC));
            if (k > 0) chk("rr_gap", 32'(gap), 32'(DWELL + 1));
        end

        // single source, then HOLD, then source 2 captured next cycle
        src_req = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        src_req = 4'b0001;
        src_data[0] = 32'h1234_5678;
        step();
        src_req = '0;
        repeat (DWELL + 3) step();
        chk("hold_state", 32'(dbg_state), 32'(S_HOLD));
        chk("hold_number", number, 32'h1234_5678);
        chk("hold_valid", 32'(active_valid), 32'h1);
        src_req = 4'b0100;
        src_data[2] = 32'hCAFE_0002;
        step();
        chk("hold_cap_number", number, 32'hCAFE_0002);
        chk("hold_cap_ack", 32'(src_ack), 32'h4);
        chk("hold_cap_src", 32'(active_src), 32'h2);
        src_req = '0;

        // override mid-SHOW, release with source 1 waiting
        step();
        chk("show_state", 32'(dbg_state), 32'(S_SHOW));
        override_valid = 1'b1;
        override_data = 32'h0000_0BAD;
        src_req = 4'b0010;
        src_data[1] = 32'hB0B0_0001;
        step();
        chk("ovr_number", number, 32'h0000_0BAD);
        chk("ovr_flag", 32'(in_override), 32'h1);
        chk("ovr_src_kept", 32'(active_src), 32'h2);
        step();
        chk("ovr_no_ack", 32'(src_ack), 32'h0);
        override_valid = 1'b0;
        step();
        chk("rel_flag", 32'(in_override), 32'h0);
        chk("rel_number", number, 32'h0000_0BAD);
        step();
        chk("rel_cap_number", number, 32'hB0B0_0001);
        chk("rel_cap_ack", 32'(src_ack), 32'h2);
        src_req = '0;

        // override and request in the same ARB cycle; then release idle
        repeat (DWELL) step();
        chk("arb_state", 32'(dbg_state), 32'(S_ARB));
        override_valid = 1'b1;
        override_data = 32'h0000_0F0F;
        src_req = 4'b1000;
        step();
        chk("tie_ovr", 32'(in_override), 32'h1);
        chk("tie_no_ack", 32'(src_ack), 32'h0);
        chk("tie_number", number, 32'h0000_0F0F);
        src_req = '0;
        step();
        override_valid = 1'b0;
        step();
        chk("idle_rel_valid", 32'(active_valid), 32'h0);
        chk("idle_rel_number", number, 32'h0000_0F0F);
        step();
        chk("idle_rel_hold", 32'(dbg_state), 32'(S_HOLD));

        // reset while an ack is high
        src_req = 4'b0100;
        src_data[2] = 32'h7777_0002;
        step();
        chk("pre_rst_ack", 32'(src_ack), 32'h4);
        src_req = '0;
        reset = 1'b1;
        step();
        chk("mid_rst_number", number, 32'h0);
        chk("mid_rst_ack", 32'(src_ack), 32'h0);
        chk("mid_rst_valid", 32'(active_valid), 32'h0);
        chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
        reset = 1'b0;
        src_req = 4'b1111;
        step();
        chk("post_rst_first", 32'(src_ack), 32'h1);
        src_req = '0;
        repeat (DWELL + 2) step();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_req[i] && src_ack[i]) begin
                    src_req[i] = 1'b0;
                end else if (!src_req[i] && $urandom_range(0, 3) == 0) begin
                    src_req[i] = 1'b1;
                    src_data[i] = $urandom;
                end
            end
            if (override_valid) begin
                if ($urandom_range(0, 7) == 0) override_valid = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                override_valid = 1'b1;
            end
            override_data = $urandom;
            reset = ($urandom_range(0, 499) == 0);
            step();
        end

        reset = 1'b0;
        override_valid = 1'b0;
        src_req = '0;
        step();
        @(negedge clk);
        check_en = 1'b0;
        hold_val = number;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
